vga_scan: RTL and testbench

Framebuffer scan-out engine: the read side of the pixel/character buffers that `draw`-style writers fill. Generates 640x480@60 VGA timing from the pixel clock and fetches the 256x256 RGB framebuffer and a 32x16 character map through synchronous-RAM read ports. Composites 8x16 font glyphs over the image, centred on screen, and drives the DAC/sync pins through a fixed 5-stage pipeline.

---
 rtl/vga_scan.sv | 178 +++++++++++++++++
 tb/tb_vga_scan.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan.sv
// Purpose : 640x480@60 VGA scan-out; reads a 256x256 RGB framebuffer and a 32x16 char map, overlays 8x16 glyphs.
// Latency : counter state reaches the pins exactly 5 cycles later; FRAME_END is 1 cycle after its counter state.
// Backpr. : none; free-running raster, RAM/ROM read ports are addressed every cycle and must answer in 1 cycle.
//
// Ports:
//   CLK, NRST      pixel clock, synchronous active-low reset
//   TXT_EN         character overlay enable, sampled with each pixel's counter state
//   FB_ADDR/DATA   framebuffer read port {fy,fx} -> {R,G,B}, data 1 cycle after address
//   CH_ADDR/DATA   character map read port {cy,cx} -> code, data 1 cycle after address
//   FONT_ADDR/DATA font ROM read port {code,row} -> glyph row (bit 7 leftmost), data 1 cycle after address
//   VGA_*          colour, active-low syncs, blank; FRAME_END pulses at start of vertical blanking
module vga_scan #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          IMG_X0   = 192,
  parameter int          IMG_Y0   = 112,
  parameter logic [23:0] BORDER   = 24'h000000,
  parameter logic [23:0] TXT_RGB  = 24'hFFFFFF
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        TXT_EN,
  output logic [15:0] FB_ADDR,
  input  logic [23:0] FB_DATA,
  output logic [8:0]  CH_ADDR,
  input  logic [7:0]  CH_DATA,
  output logic [11:0] FONT_ADDR,
  input  logic [7:0]  FONT_DATA,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        FRAME_END
);

  localparam logic [9:0] C_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] C_HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] C_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] C_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] C_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] C_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] C_X0     = 10'(IMG_X0);
  localparam logic [9:0] C_Y0     = 10'(IMG_Y0);

  // Per-pixel sideband travelling alongside the memory reads.
  typedef struct packed {
    logic       active;
    logic       in_img;
    logic       hs;
    logic       vs;
    logic       txt;
    logic [2:0] col;
  } meta_t;

  logic [9:0]  r_hc, r_vc;
  logic [9:0]  w_dx, w_dy;
  logic        w_active;
  meta_t       w_meta0;
  meta_t       r_meta1, r_meta2, r_meta3, r_meta4;
  logic [3:0]  r_row1, r_row2;
  logic [15:0] r_fb_addr;
  logic [8:0]  r_ch_addr;
  logic [11:0] r_font_addr;
  logic [23:0] r_fb3, r_fb4;
  logic [7:0]  r_char3, r_char4;
  logic        w_glyph;
  logic [23:0] w_rgb;
  logic [23:0] r_rgb;
  logic        r_hs_n, r_vs_n, r_blank_n, r_frame_end;

  // Raster counters
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == C_H_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == C_V_LAST) ? '0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  // Stage 0 decode. Offsets wrap modulo 1024, so anything left of / above
  // the image lands far above 255 and fails the in-image compare.
  assign w_dx     = r_hc - C_X0;
  assign w_dy     = r_vc - C_Y0;
  assign w_active = (r_hc < C_H_ACT) && (r_vc < C_V_ACT);

  always_comb begin
    w_meta0        = '0;
    w_meta0.active = w_active;
    w_meta0.in_img = w_active && (w_dx < 10'd256) && (w_dy < 10'd256);
    w_meta0.hs     = (r_hc >= C_HS_BEG) && (r_hc < C_HS_END);
    w_meta0.vs     = (r_vc >= C_VS_BEG) && (r_vc < C_VS_END);
    w_meta0.txt    = TXT_EN;
    w_meta0.col    = w_dx[2:0];
  end

  // Stage 4 colour select; FONT_DATA for this pixel is valid now.
  assign w_glyph = FONT_DATA[3'd7 - r_meta4.col];

  always_comb begin
    w_rgb = r_fb4;
    if (!r_meta4.active) begin
      w_rgb = '0;
    end else if (!r_meta4.in_img) begin
      w_rgb = BORDER;
    end else if (r_meta4.txt && (r_char4 != 8'd0) && w_glyph) begin
      w_rgb = TXT_RGB;
    end
  end

  // Pipeline: S1 addresses, S2 font address + FB delay, S3/S4 delay, S5 pins.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_meta1     <= '0;
      r_meta2     <= '0;
      r_meta3     <= '0;
      r_meta4     <= '0;
      r_row1      <= '0;
      r_row2      <= '0;
      r_fb_addr   <= '0;
      r_ch_addr   <= '0;
      r_font_addr <= '0;
      r_fb3       <= '0;
      r_fb4       <= '0;
      r_char3     <= '0;
      r_char4     <= '0;
      r_rgb       <= '0;
      r_hs_n      <= 1'b1;
      r_vs_n      <= 1'b1;
      r_blank_n   <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_fb_addr   <= {w_dy[7:0], w_dx[7:0]};
      r_ch_addr   <= {w_dy[7:4], w_dx[7:3]};
      r_meta1     <= w_meta0;
      r_meta2     <= r_meta1;
      r_meta3     <= r_meta2;
      r_meta4     <= r_meta3;
      r_row1      <= w_dy[3:0];
      r_row2      <= r_row1;
      r_font_addr <= {CH_DATA, r_row2};
      r_char3     <= CH_DATA;
      r_char4     <= r_char3;
      r_fb3       <= FB_DATA;
      r_fb4       <= r_fb3;
      r_rgb       <= w_rgb;
      r_hs_n      <= ~r_meta4.hs;
      r_vs_n      <= ~r_meta4.vs;
      r_blank_n   <= r_meta4.active;
      r_frame_end <= (r_hc == 10'd0) && (r_vc == C_V_ACT);
    end
  end

  assign FB_ADDR     = r_fb_addr;
  assign CH_ADDR     = r_ch_addr;
  assign FONT_ADDR   = r_font_addr;
  assign VGA_R       = r_rgb[23:16];
  assign VGA_G       = r_rgb[15:8];
  assign VGA_B       = r_rgb[7:0];
  assign VGA_HS      = r_hs_n;
  assign VGA_VS      = r_vs_n;
  assign VGA_BLANK_N = r_blank_n;
  assign FRAME_END   = r_frame_end;

endmodule

// File: tb/tb_vga_scan.sv
// Purpose : self-checking bench for vga_scan on a shrunken raster (320x48 total) so two frames fit the cycle budget.
// Latency : reference model predicts pins 5 cycles, addresses 1/3 cycles and FRAME_END 1 cycle after counter state.
// Backpr. : none; RAM/ROM models answer one cycle after each address.
module tb_vga_scan;

  localparam int HA = 288, HFP = 8, HSW = 16, HBP = 8;
  localparam int VA = 40,  VFP = 2, VSW = 2,  VBP = 4;
  localparam int X0 = 16,  Y0 = 8;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BORDER_C = 24'h204060;
  localparam logic [23:0] TXT_C    = 24'hFFFFFF;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic        TXT_EN = 1'b0;
  logic [15:0] FB_ADDR;
  logic [23:0] FB_DATA;
  logic [8:0]  CH_ADDR;
  logic [7:0]  CH_DATA;
  logic [11:0] FONT_ADDR;
  logic [7:0]  FONT_DATA;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, FRAME_END;

  logic [23:0] fb_mem   [65536];
  logic [7:0]  ch_mem   [512];
  logic [7:0]  font_mem [4096];

  int n;                 // cycles since reset release; counter state of cycle n is pixel n
  bit txt_hist [16];     // TXT_EN seen by recent pixels
  int vec_cnt = 0;
  int err_cnt = 0;

  vga_scan #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .IMG_X0(X0), .IMG_Y0(Y0), .BORDER(BORDER_C), .TXT_RGB(TXT_C)
  ) dut (
    .CLK(CLK), .NRST(NRST), .TXT_EN(TXT_EN),
    .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA),
    .CH_ADDR(CH_ADDR), .CH_DATA(CH_DATA),
    .FONT_ADDR(FONT_ADDR), .FONT_DATA(FONT_DATA),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .FRAME_END(FRAME_END)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read memories
  always @(posedge CLK) begin
    FB_DATA   <= fb_mem[FB_ADDR];
    CH_DATA   <= ch_mem[CH_ADDR];
    FONT_DATA <= font_mem[FONT_ADDR];
  end

  // ---------------- reference model (screen arithmetic) ----------------
  function automatic int hpos(input int p); return p % HT; endfunction
  function automatic int vpos(input int p); return (p / HT) % VT; endfunction
  function automatic int fxw(input int p); return (hpos(p) - X0) & 255; endfunction
  function automatic int fyw(input int p); return (vpos(p) - Y0) & 255; endfunction

  function automatic logic [15:0] m_fb_addr(input int p);
    return 16'(fyw(p) * 256 + fxw(p));
  endfunction

  function automatic logic [8:0] m_ch_addr(input int p);
    return 9'((fyw(p) / 16) * 32 + fxw(p) / 8);
  endfunction

  function automatic logic [11:0] m_font_addr(input int p);
    return 12'(int'(ch_mem[m_ch_addr(p)]) * 16 + fyw(p) % 16);
  endfunction

  function automatic logic [23:0] m_rgb(input int p, input bit txt);
    int h, v, x, y;
    logic [7:0] code, glyph;
    h = hpos(p); v = vpos(p); x = h - X0; y = v - Y0;
    if (h >= HA || v >= VA) return 24'h0;
    if (x < 0 || x > 255 || y < 0 || y > 255) return BORDER_C;
    code  = ch_mem[9'((y / 16) * 32 + x / 8)];
    glyph = font_mem[12'(int'(code) * 16 + y % 16)];
    if (txt && code != 8'h00 && glyph[7 - x % 8]) return TXT_C;
    return fb_mem[16'(y * 256 + x)];
  endfunction

  function automatic bit m_hs_n(input int p);
    return !(hpos(p) >= HA + HFP && hpos(p) < HA + HFP + HSW);
  endfunction

  function automatic bit m_vs_n(input int p);
    return !(vpos(p) >= VA + VFP && vpos(p) < VA + VFP + VSW);
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick(input bit txt);
    @(posedge CLK);
    n = n + 1;
    #1;
    TXT_EN = txt;
    txt_hist[n % 16] = txt;
  endtask

  task automatic run_to(input int h, input int v, input bit txt);
    tick(txt);
    for (int i = 0; i <= FRAME && !(hpos(n) == h && vpos(n) == v); i++) tick(txt);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    NRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin err_cnt++; $display("FAIL reset_rgb got %06h want 000000", {VGA_R, VGA_G, VGA_B}); end
    vec_cnt++; if (VGA_HS !== 1'b1) begin err_cnt++; $display("FAIL reset_hs got %b want 1", VGA_HS); end
    vec_cnt++; if (VGA_VS !== 1'b1) begin err_cnt++; $display("FAIL reset_vs got %b want 1", VGA_VS); end
    vec_cnt++; if (VGA_BLANK_N !== 1'b0) begin err_cnt++; $display("FAIL reset_blank got %b want 0", VGA_BLANK_N); end
    vec_cnt++; if (FRAME_END !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_end got %b want 0", FRAME_END); end
    vec_cnt++; if (FB_ADDR !== 16'h0) begin err_cnt++; $display("FAIL reset_fb_addr got %04h want 0000", FB_ADDR); end
    vec_cnt++; if (CH_ADDR !== 9'h0) begin err_cnt++; $display("FAIL reset_ch_addr got %03h want 000", CH_ADDR); end
    vec_cnt++; if (FONT_ADDR !== 12'h0) begin err_cnt++; $display("FAIL reset_font_addr got %03h want 000", FONT_ADDR); end
    @(posedge CLK);
    #1;
    NRST = 1'b1;
    n = 0;
    TXT_EN = 1'b0;
    txt_hist[0] = 1'b0;
  endtask

  task automatic test_two_frames();
    logic [23:0] e_rgb;
    bit e_blank, e_hs, e_vs, e_fe;
    for (int k = 0; k < 2 * FRAME + 2 * HT; k++) begin
      @(negedge CLK);
      if (n >= 5) begin
        e_rgb   = m_rgb(n - 5, txt_hist[(n - 5) % 16]);
        e_blank = (hpos(n - 5) < HA) && (vpos(n - 5) < VA);
        e_hs    = m_hs_n(n - 5);
        e_vs    = m_vs_n(n - 5);
      end else begin
        e_rgb = 24'h0; e_blank = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end
      e_fe = (n >= 1) && ((n - 1) % FRAME == VA * HT);
      vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== e_rgb) begin err_cnt++; $display("FAIL frame_rgb n=%0d got %06h want %06h", n, {VGA_R, VGA_G, VGA_B}, e_rgb); end
      vec_cnt++; if (VGA_BLANK_N !== e_blank) begin err_cnt++; $display("FAIL frame_blank n=%0d got %b want %b", n, VGA_BLANK_N, e_blank); end
      vec_cnt++; if (VGA_HS !== e_hs) begin err_cnt++; $display("FAIL frame_hs n=%0d got %b want %b", n, VGA_HS, e_hs); end
      vec_cnt++; if (VGA_VS !== e_vs) begin err_cnt++; $display("FAIL frame_vs n=%0d got %b want %b", n, VGA_VS, e_vs); end
      vec_cnt++; if (FRAME_END !== e_fe) begin err_cnt++; $display("FAIL frame_end n=%0d got %b want %b", n, FRAME_END, e_fe); end
      vec_cnt++; if (FB_ADDR !== ((n >= 1) ? m_fb_addr(n - 1) : 16'h0)) begin err_cnt++; $display("FAIL frame_fb_addr n=%0d got %04h", n, FB_ADDR); end
      vec_cnt++; if (CH_ADDR !== ((n >= 1) ? m_ch_addr(n - 1) : 9'h0)) begin err_cnt++; $display("FAIL frame_ch_addr n=%0d got %03h", n, CH_ADDR); end
      if (n >= 3) begin
        vec_cnt++; if (FONT_ADDR !== m_font_addr(n - 3)) begin err_cnt++; $display("FAIL frame_font_addr n=%0d got %03h want %03h", n, FONT_ADDR, m_font_addr(n - 3)); end
      end
      tick($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_border();
    run_to(4, 4, 1'b0);
    repeat (5) tick(1'b0);
    @(negedge CLK);
    vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== BORDER_C) begin err_cnt++; $display("FAIL border_rgb got %06h want %06h", {VGA_R, VGA_G, VGA_B}, BORDER_C); end
    vec_cnt++; if (VGA_BLANK_N !== 1'b1) begin err_cnt++; $display("FAIL border_blank got %b want 1", VGA_BLANK_N); end
    run_to(HA + 10, 4, 1'b0);
    repeat (5) tick(1'b0);
    @(negedge CLK);
    vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin err_cnt++; $display("FAIL hblank_rgb got %06h want 000000", {VGA_R, VGA_G, VGA_B}); end
    vec_cnt++; if (VGA_BLANK_N !== 1'b0) begin err_cnt++; $display("FAIL hblank_blank got %b want 0", VGA_BLANK_N); end
  endtask

  task automatic test_fb_pixel();
    run_to(X0, Y0, 1'b0);
    tick(1'b0);
    @(negedge CLK);
    vec_cnt++; if (FB_ADDR !== 16'h0000) begin err_cnt++; $display("FAIL origin_fb_addr got %04h want 0000", FB_ADDR); end
    repeat (4) tick(1'b0);
    @(negedge CLK);
    vec_cnt++; if (VGA_R !== 8'h12) begin err_cnt++; $display("FAIL origin_r got %02h want 12", VGA_R); end
    vec_cnt++; if (VGA_G !== 8'h34) begin err_cnt++; $display("FAIL origin_g got %02h want 34", VGA_G); end
    vec_cnt++; if (VGA_B !== 8'h56) begin err_cnt++; $display("FAIL origin_b got %02h want 56", VGA_B); end
    vec_cnt++; if (VGA_BLANK_N !== 1'b1) begin err_cnt++; $display("FAIL origin_blank got %b want 1", VGA_BLANK_N); end
  endtask

  task automatic test_overlay();
    run_to(X0 + 8, Y0, 1'b1);
    repeat (5) tick(1'b1);
    @(negedge CLK);
    vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin err_cnt++; $display("FAIL overlay_on got %06h want ffffff", {VGA_R, VGA_G, VGA_B}); end
    tick(1'b1);
    @(negedge CLK);
    vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'hA5C3E1) begin err_cnt++; $display("FAIL overlay_next got %06h want a5c3e1", {VGA_R, VGA_G, VGA_B}); end
    run_to(X0 + 8, Y0, 1'b0);
    repeat (5) tick(1'b0);
    @(negedge CLK);
    vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0F1E2D) begin err_cnt++; $display("FAIL overlay_off got %06h want 0f1e2d", {VGA_R, VGA_G, VGA_B}); end
  endtask

  task automatic test_transparent();
    run_to(X0 + 16, Y0, 1'b1);
    repeat (5) tick(1'b1);
    @(negedge CLK);
    vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h5A6B7C) begin err_cnt++; $display("FAIL transparent got %06h want 5a6b7c", {VGA_R, VGA_G, VGA_B}); end
  endtask

  // TXT_EN toggled every pixel over a solid glyph row
  task automatic test_back_to_back();
    logic [23:0] e_rgb;
    run_to(X0 + 24, Y0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      if (i >= 5) begin
        e_rgb = ((i - 5) % 2 == 0) ? 24'hFFFFFF : fb_mem[16'(24 + i - 5)];
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== e_rgb) begin err_cnt++; $display("FAIL txt_toggle px=%0d got %06h want %06h", i - 5, {VGA_R, VGA_G, VGA_B}, e_rgb); end
      end
      tick((i + 1 < 8) ? ((i + 1) % 2 == 0) : 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    run_to(150, 20, 1'b1);
    NRST = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(posedge CLK);
      #1;
      if (r == 2) begin
        NRST = 1'b1;
        n = 0;
        TXT_EN = 1'b1;
        txt_hist[0] = 1'b1;
      end
      @(negedge CLK);
      vec_cnt++; if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N} !== {24'h0, 3'b110}) begin err_cnt++; $display("FAIL midrst_pins r=%0d got %06h %b%b%b want 000000 110", r, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N); end
      vec_cnt++; if (FB_ADDR !== 16'h0) begin err_cnt++; $display("FAIL midrst_fb_addr r=%0d got %04h want 0000", r, FB_ADDR); end
    end
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1);
      @(negedge CLK);
      if (k == 1) begin
        vec_cnt++; if (FB_ADDR !== m_fb_addr(0)) begin err_cnt++; $display("FAIL midrst_restart_addr got %04h want %04h", FB_ADDR, m_fb_addr(0)); end
      end
      if (k < 5) begin
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS} !== {24'h0, 2'b01}) begin err_cnt++; $display("FAIL midrst_stale k=%0d got %06h blank=%b hs=%b", k, {VGA_R, VGA_G, VGA_B}, VGA_BLANK_N, VGA_HS); end
      end else begin
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== BORDER_C || VGA_BLANK_N !== 1'b1) begin err_cnt++; $display("FAIL midrst_first k=%0d got %06h blank=%b want %06h blank=1", k, {VGA_R, VGA_G, VGA_B}, VGA_BLANK_N, BORDER_C); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) fb_mem[i] = 24'($urandom);
    for (int i = 0; i < 512; i++) ch_mem[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
    // directed contents
    fb_mem[0]  = 24'h123456; ch_mem[0] = 8'h00;
    ch_mem[1]  = 8'h41; font_mem[12'h410] = 8'h80;
    fb_mem[8]  = 24'h0F1E2D; fb_mem[9] = 24'hA5C3E1;
    ch_mem[2]  = 8'h00; font_mem[12'h000] = 8'hFF; fb_mem[16] = 24'h5A6B7C;
    ch_mem[3]  = 8'h7F; font_mem[12'h7F0] = 8'hFF;
    n = 0;

    test_reset();
    test_two_frames();
    test_border();
    test_fb_pixel();
    test_overlay();
    test_transparent();
    test_back_to_back();
    test_mid_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
